// File: rtl/hid_report_events.sv
// rtl/hid_report_events.sv - HID boot report capture, diff engine and make/break event FIFO
module hid_report_events #(
  parameter int REPORT_BYTES = 8,
  parameter int KEY_FIRST    = 2,
  parameter int FIFO_AW      = 3
) (
  input  logic                      usbclk,
  input  logic                      usbrst,
  input  logic                      ukprdy,
  input  logic                      ukpstb,
  input  logic [7:0]                ukpdat,
  input  logic                      conerr,
  output logic [8*REPORT_BYTES-1:0] report,
  output logic                      new_packet,
  output logic                      ev_valid,
  output logic [8:0]                ev_data,
  input  logic                      ev_ready,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic                      busy
);

  localparam int N  = REPORT_BYTES - KEY_FIRST;
  localparam int IW = $clog2(REPORT_BYTES + 1);
  localparam int SW = (REPORT_BYTES > 2) ? $clog2(REPORT_BYTES) : 1;
  localparam int PW = FIFO_AW + 1;
  localparam logic [SW-1:0] LAST     = SW'(N - 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(REPORT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_MOD, S_BRK, S_MAK} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                bit_q, bit_d;
  logic [SW-1:0]             outer_q, outer_d, inner_q, inner_d;
  logic                      match_q, match_d;
  logic                      pending_q, pending_d, pend_zero_q, pend_zero_d;
  logic                      stb_q, stb_qq, rdy_q, rdy_qq, cerr_q, cerr_qq;
  logic [IW-1:0]             idx_q;
  logic [8*REPORT_BYTES-1:0] shadow_q, report_q, prev_q;
  logic                      newpkt_q, ovf_q;
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [8:0]                mem_q [2**FIFO_AW];

  logic       stb_rise, cerr_rise, frame_end, cap, valid_end, has_err;
  logic       idle, commit, commit_zero;
  logic [7:0] old_outer, new_outer, old_inner, new_inner, cur_a, cur_b;
  logic [7:0] prev_mod, rep_mod;
  logic       hit, emit;
  logic [8:0] emit_data;
  logic       empty, full, pop, push;

  assign stb_rise  = stb_q & ~stb_qq;
  assign cerr_rise = cerr_q & ~cerr_qq;
  assign frame_end = rdy_qq & ~rdy_q;
  assign cap       = stb_rise & rdy_q & ~pending_q & (idx_q != FULL_IDX);
  assign valid_end = frame_end & (idx_q == FULL_IDX) & ~has_err & ~pending_q & ~cerr_rise;
  assign idle      = (state_q == S_IDLE);
  assign commit    = idle & (cerr_rise | pending_q | valid_end);
  // A connection loss always wins over any held or simultaneous frame.
  assign commit_zero = cerr_rise | (pending_q & pend_zero_q);

  always_comb begin
    old_outer = '0;
    new_outer = '0;
    old_inner = '0;
    new_inner = '0;
    has_err   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (outer_q == SW'(k)) begin
        old_outer = prev_q[8*(KEY_FIRST+k) +: 8];
        new_outer = report_q[8*(KEY_FIRST+k) +: 8];
      end
      if (inner_q == SW'(k)) begin
        old_inner = prev_q[8*(KEY_FIRST+k) +: 8];
        new_inner = report_q[8*(KEY_FIRST+k) +: 8];
      end
      if (shadow_q[8*(KEY_FIRST+k) +: 8] == 8'h01) has_err = 1'b1;
    end
  end

  // BRK scans old slots against new ones; MAK swaps the roles.
  assign cur_a    = (state_q == S_MAK) ? new_outer : old_outer;
  assign cur_b    = (state_q == S_MAK) ? old_inner : new_inner;
  assign hit      = (cur_a == cur_b);
  assign prev_mod = prev_q[7:0];
  assign rep_mod  = report_q[7:0];

  always_comb begin
    pending_d   = pending_q;
    pend_zero_d = pend_zero_q;
    if (commit) begin
      pending_d   = 1'b0;
      pend_zero_d = 1'b0;
    end else if (cerr_rise) begin
      pending_d   = 1'b1;
      pend_zero_d = 1'b1;
    end else if (valid_end) begin
      pending_d   = 1'b1;
      pend_zero_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    outer_d   = outer_q;
    inner_d   = inner_q;
    match_d   = match_q;
    emit      = 1'b0;
    emit_data = '0;
    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_MOD;
          bit_d   = '0;
        end
      end
      S_MOD: begin
        if (prev_mod[bit_q] != rep_mod[bit_q]) begin
          emit      = 1'b1;
          emit_data = {rep_mod[bit_q], 5'b11100, bit_q};
        end
        if (bit_q == 3'd7) begin
          state_d = S_BRK;
          outer_d = '0;
          inner_d = '0;
          match_d = 1'b0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_BRK, S_MAK: begin
        if (inner_q == LAST) begin
          if (cur_a != 8'h00 && !(match_q | hit)) begin
            emit      = 1'b1;
            emit_data = {(state_q == S_MAK), cur_a};
          end
          inner_d = '0;
          match_d = 1'b0;
          if (outer_q == LAST) begin
            outer_d = '0;
            state_d = (state_q == S_BRK) ? S_MAK : S_IDLE;
          end else begin
            outer_d = outer_q + SW'(1);
          end
        end else begin
          inner_d = inner_q + SW'(1);
          match_d = match_q | hit;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop   = ~empty & ev_ready;
  assign push  = emit & (~full | pop);

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      state_q     <= S_IDLE;
      bit_q       <= '0;
      outer_q     <= '0;
      inner_q     <= '0;
      match_q     <= 1'b0;
      pending_q   <= 1'b0;
      pend_zero_q <= 1'b0;
      stb_q       <= 1'b0;
      stb_qq      <= 1'b0;
      rdy_q       <= 1'b0;
      rdy_qq      <= 1'b0;
      cerr_q      <= 1'b0;
      cerr_qq     <= 1'b0;
      idx_q       <= '0;
      shadow_q    <= '0;
      report_q    <= '0;
      prev_q      <= '0;
      newpkt_q    <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      outer_q     <= outer_d;
      inner_q     <= inner_d;
      match_q     <= match_d;
      pending_q   <= pending_d;
      pend_zero_q <= pend_zero_d;
      stb_q       <= ukpstb;
      stb_qq      <= stb_q;
      rdy_q       <= ukprdy;
      rdy_qq      <= rdy_q;
      cerr_q      <= conerr;
      cerr_qq     <= cerr_q;
      if (!rdy_q) idx_q <= '0;
      else if (cap) idx_q <= idx_q + IW'(1);
      for (int k = 0; k < REPORT_BYTES; k++) begin
        if (cap && idx_q == IW'(k)) shadow_q[8*k +: 8] <= ukpdat;
      end
      if (commit) begin
        prev_q   <= report_q;
        report_q <= commit_zero ? '0 : shadow_q;
        if (!commit_zero) newpkt_q <= ~newpkt_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (emit && !push) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge usbclk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= emit_data;
  end

  assign report     = report_q;
  assign new_packet = newpkt_q;
  assign busy       = ~idle;
  assign overflow   = ovf_q;
  assign ev_valid   = ~empty;
  assign ev_data    = empty ? 9'h000 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: tb/tb_hid_report_events.sv
// tb/tb_hid_report_events.sv - directed bench for hid_report_events
module tb_hid_report_events;

  logic        usbclk = 1'b0;
  logic        usbrst = 1'b1;
  logic        ukprdy = 1'b0;
  logic        ukpstb = 1'b0;
  logic [7:0]  ukpdat = 8'h00;
  logic        conerr = 1'b0;
  logic        ev_ready = 1'b1;
  logic        ev_ready_s = 1'b1;
  logic        ovf_clr = 1'b0;

  logic [63:0] report, report_s;
  logic        new_packet, new_packet_s;
  logic        ev_valid, ev_valid_s;
  logic [8:0]  ev_data, ev_data_s;
  logic        overflow, overflow_s;
  logic        busy, busy_s;

  int n_err = 0;
  int n_chk = 0;
  logic [8:0] evq[$];

  hid_report_events #(.REPORT_BYTES(8), .KEY_FIRST(2), .FIFO_AW(3)) dut (
    .usbclk(usbclk), .usbrst(usbrst), .ukprdy(ukprdy), .ukpstb(ukpstb),
    .ukpdat(ukpdat), .conerr(conerr), .report(report), .new_packet(new_packet),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
    .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
  );

  hid_report_events #(.REPORT_BYTES(8), .KEY_FIRST(2), .FIFO_AW(1)) dut_s (
    .usbclk(usbclk), .usbrst(usbrst), .ukprdy(ukprdy), .ukpstb(ukpstb),
    .ukpdat(ukpdat), .conerr(conerr), .report(report_s), .new_packet(new_packet_s),
    .ev_valid(ev_valid_s), .ev_data(ev_data_s), .ev_ready(ev_ready_s),
    .overflow(overflow_s), .ovf_clr(ovf_clr), .busy(busy_s)
  );

  always #5 usbclk = ~usbclk;

  always @(negedge usbclk) begin
    if (ev_valid && ev_ready) evq.push_back(ev_data);
  end

  task automatic tick;
    @(posedge usbclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [127:0] f, input int n);
    ukprdy = 1'b1;
    tick;
    for (int k = 0; k < n; k++) begin
      ukpdat = f[8*k +: 8];
      ukpstb = 1'b1;
      tick;
      tick;
      ukpstb = 1'b0;
      tick;
      tick;
    end
    ukprdy = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      tick;
    end
    repeat (4) tick;
  endtask

  task automatic expect_events(input string tag, input int n, input logic [71:0] exp);
    logic [8:0] got;
    check($sformatf("%s count", tag), 64'(evq.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      got = (k < evq.size()) ? evq[k] : 9'h000;
      check($sformatf("%s ev%0d", tag, k), 64'(got), 64'(exp[9*k +: 9]));
    end
    evq.delete();
  endtask

  task automatic run_frame(input logic [63:0] f, input int n, output int cnt);
    send_frame({64'd0, f}, n);
    tick;
    tick;
    wait_idle(cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    repeat (3) tick;
    check("rst report", report, 64'd0);
    check("rst new_packet", 64'(new_packet), 64'd0);
    check("rst ev_valid", 64'(ev_valid), 64'd0);
    check("rst ev_data", 64'(ev_data), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    usbrst = 1'b0;
    tick;

    // single press with commit latency
    send_frame({64'd0, 64'h0000_0000_0004_0000}, 8);
    tick;
    check("t1 report before commit", report, 64'd0);
    tick;
    check("t1 report", report, 64'h0000_0000_0004_0000);
    check("t1 key byte", 64'(report[23:16]), 64'h04);
    check("t1 new_packet", 64'(new_packet), 64'd1);
    wait_idle(cnt);
    check("t1 busy cycles", 64'(cnt), 64'd80);
    expect_events("t1", 1, {63'd0, 9'h104});

    // modifier press, then release of everything
    run_frame(64'h0000_0000_0000_0002, 8, cnt);
    expect_events("t2 mod", 2, {54'd0, 9'h004, 9'h1E1});
    run_frame(64'h0, 8, cnt);
    expect_events("t2 rel", 1, {63'd0, 9'h0E1});
    check("t2 new_packet", 64'(new_packet), 64'd1);

    // swap order
    run_frame(64'h0000_0000_0504_0000, 8, cnt);
    expect_events("t3 hold", 2, {54'd0, 9'h105, 9'h104});
    run_frame(64'h0000_0000_0605_0000, 8, cnt);
    check("t3 busy cycles", 64'(cnt), 64'd80);
    expect_events("t3 swap", 2, {54'd0, 9'h106, 9'h004});

    // rejected frames
    run_frame(64'h0000_0000_0001_0000, 8, cnt);
    check("t4 rollover busy", 64'(cnt), 64'd0);
    check("t4 rollover report", report, 64'h0000_0000_0605_0000);
    run_frame(64'h0000_0000_0007_0000, 5, cnt);
    check("t4 short busy", 64'(cnt), 64'd0);
    check("t4 short report", report, 64'h0000_0000_0605_0000);
    check("t4 new_packet", 64'(new_packet), 64'd1);
    expect_events("t4", 0, 72'd0);

    // conerr release, then a frame held pending behind the diff
    run_frame(64'h0000_0000_0004_0000, 8, cnt);
    expect_events("t5 hold", 3, {45'd0, 9'h104, 9'h006, 9'h005});
    conerr = 1'b1;
    tick;
    check("t5 report before conerr commit", report, 64'h0000_0000_0004_0000);
    tick;
    conerr = 1'b0;
    check("t5 conerr report", report, 64'd0);
    check("t5 conerr new_packet", 64'(new_packet), 64'd0);
    send_frame({64'd0, 64'h0000_0000_0007_0000}, 8);
    tick;
    tick;
    check("t5 pending report", report, 64'd0);
    check("t5 pending busy", 64'(busy), 64'd1);
    repeat (200) tick;
    check("t5 pending commit report", report, 64'h0000_0000_0007_0000);
    check("t5 new_packet", 64'(new_packet), 64'd1);
    expect_events("t5", 2, {54'd0, 9'h107, 9'h004});

    // overflow on the depth-2 instance
    run_frame(64'h0, 8, cnt);
    expect_events("t6 rel", 1, {63'd0, 9'h007});
    check("t6 ovf before", 64'(overflow_s), 64'd0);
    ev_ready_s = 1'b0;
    run_frame(64'h0F0E_0D0C_0B0A_0000, 8, cnt);
    expect_events("t6 main", 6, {18'd0, 9'h10F, 9'h10E, 9'h10D, 9'h10C, 9'h10B, 9'h10A});
    check("t6 main overflow", 64'(overflow), 64'd0);
    check("t6 small report", report_s, 64'h0F0E_0D0C_0B0A_0000);
    check("t6 overflow", 64'(overflow_s), 64'd1);
    check("t6 valid", 64'(ev_valid_s), 64'd1);
    check("t6 head0", 64'(ev_data_s), 64'h10A);
    ev_ready_s = 1'b1;
    tick;
    ev_ready_s = 1'b0;
    check("t6 head1", 64'(ev_data_s), 64'h10B);
    ev_ready_s = 1'b1;
    tick;
    ev_ready_s = 1'b0;
    check("t6 drained", 64'(ev_valid_s), 64'd0);
    check("t6 overflow sticky", 64'(overflow_s), 64'd1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    check("t6 ovf_clr", 64'(overflow_s), 64'd0);
    ev_ready_s = 1'b1;

    // reset in the middle of a diff
    send_frame({64'd0, 64'h0000_0000_0004_0000}, 8);
    tick;
    tick;
    repeat (10) tick;
    check("t7 busy before reset", 64'(busy), 64'd1);
    check("t7 report before reset", report, 64'h0000_0000_0004_0000);
    usbrst = 1'b1;
    #1;
    check("t7 reset report", report, 64'd0);
    check("t7 reset busy", 64'(busy), 64'd0);
    check("t7 reset new_packet", 64'(new_packet), 64'd0);
    check("t7 reset ev_valid", 64'(ev_valid), 64'd0);
    check("t7 reset small busy", 64'(busy_s), 64'd0);
    check("t7 reset small new_packet", 64'(new_packet_s), 64'd0);
    tick;
    usbrst = 1'b0;
    evq.delete();
    repeat (3) tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hid_report_events.md
# hid_report_events

Parametrised successor to the fixed 8-byte keyboard capture stage. It sits between the low-speed USB host engine (`ukp`) and the keyboard-matrix translator. It captures HID boot-protocol reports of configurable length from the host engine's byte-strobe stream, and holds the last committed report. It differences each new report against the previous one and emits ordered make/break key events through a FIFO, synthesising releases on connection loss.

## Interface
Parameters:
- `REPORT_BYTES`, 8: bytes per report frame (3..16).
- `KEY_FIRST`, 2: index of the first key-code byte. Key slots are bytes `KEY_FIRST..REPORT_BYTES-1`, so N = `REPORT_BYTES-KEY_FIRST`.
- `FIFO_AW`, 3: event FIFO address width, depth 2^`FIFO_AW`.

Ports:
- `usbclk` in 1: 12 MHz clock.
- `usbrst` in 1: reset, asynchronous, active-high.
- `ukprdy` in 1: frame envelope from host engine; high while report bytes arrive.
- `ukpstb` in 1: byte strobe, level; rising edge marks `ukpdat` valid.
- `ukpdat` in 8: received byte.
- `conerr` in 1: connection error / watchdog from host engine.
- `report` out 8*`REPORT_BYTES`: last committed report, byte 0 in bits [7:0].
- `new_packet` out 1: toggles on every commit.
- `ev_valid` out 1: FIFO non-empty.
- `ev_data` out 9: [8] 1 = make, 0 = break; [7:0] HID usage code.
- `ev_ready` in 1: consumer pop; a pop occurs on `ev_valid & ev_ready`.
- `overflow` out 1: sticky; set when an event is dropped.
- `ovf_clr` in 1: clears `overflow`.
- `busy` out 1: diff engine active.

## Operation
- **Capture.** `ukpstb` is registered once, and an edge is detected on it.
  - Each rising edge while `ukprdy`=1 writes `ukpdat` to `shadow[idx]` and increments `idx`.
  - `idx` saturates at `REPORT_BYTES`; extra bytes are ignored.
  - `idx` clears while `ukprdy`=0.
- **Frame end.** The falling edge of `ukprdy` (registered) is the frame end. A frame is valid iff `idx == REPORT_BYTES` and no key slot equals 0x01 (ErrorRollOver). Invalid frames are discarded silently.
- **Commit.** On a valid frame end with the engine IDLE:
  - `report` ← `shadow`.
  - `new_packet` toggles.
  - Old report is copied to `prev`.
  - Engine starts.
- **Pending.** If the engine is busy at frame end, the frame is held `pending` and committed on the first IDLE cycle.
- **Capture lockout.** While `pending`=1, capture is locked out. Strobes are ignored and any frame ending in that state is discarded.
- **conerr.** A rising edge of `conerr` (registered) commits an all-zero report through the same path, so held keys produce breaks. It takes priority over a simultaneous valid frame end, which is discarded. It does not toggle `new_packet`.
- **State machine** (IDLE, MOD, BRK, MAK):
  - IDLE → MOD on commit.
  - MOD: bit i = 0..7, one bit per cycle. If `prev[0][i] != report[0][i]`, emit {new bit, 0xE0+i}. After i=7 → BRK.
  - BRK: old slot i = 0..N-1, new slot j = 0..N-1, one (i,j) pair per cycle. On the last j, if old[i] ≠ 0 and matched no new slot, emit {0, old[i]}. After (N-1, N-1) → MAK.
  - MAK: same scan with roles swapped. Emit {1, new[j]} for each new slot ≠ 0 absent from old. After the last pair → IDLE.
- **Duplicate codes.** Duplicate codes within a report each emit an event; this behaviour is accepted.
- **Event ordering.** Modifiers ascending, then breaks in old-slot order, then makes in new-slot order.
- **FIFO.** First-word fall-through: `ev_data` = head entry.
  - A push is accepted if not full or a pop occurs the same cycle.
  - Otherwise the event is dropped and `overflow` ← 1.
  - `ovf_clr` clears `overflow`; a simultaneous set wins.
  - Read and write pointers are `FIFO_AW`+1 bits wide with natural wrap.

## Timing
- **Reset values.**
  - `report`, `prev`, `shadow` = 0.
  - `new_packet` = 0, `ev_valid` = 0, `ev_data` = 0, `overflow` = 0, `busy` = 0.
  - FIFO empty; `idx` = 0.
  - State IDLE; `pending` = 0.
- **Commit latency.** `report` and `new_packet` update 2 cycles after the `ukprdy` falling edge (1 cycle for the input register, 1 for commit).
- **Diff duration.** The engine is busy for exactly 8 + 2·N² cycles after the commit (80 for N=6). `busy` is high for those cycles.
- **Event latency.** An event is written on its emit cycle. `ev_valid` rises the following cycle.
- **Pop behaviour.** Pop takes effect at the clock edge; the next entry is visible the following cycle.
- **Reset mid-operation.** Asserting `usbrst` mid-frame or mid-diff returns all state to reset values immediately. No partial commit occurs.

## Test plan
- **Single press.** Reset, then frame 00 00 04 00 00 00 00 00 → exactly one event 0x104; `new_packet` toggles; `report[23:16]`=0x04.
- **Modifier and release.** Frame 02 00 00… then all-zero frame → events 0x1E1, then 0x0E1.
- **Swap order.** Held {04,05} → frame with {05,06} → events 0x004 then 0x106, in that order, 80 cycles total busy.
- **Rejected frames.** A frame with a slot = 0x01, and a 5-byte short frame → no commit, no events, `report` unchanged.
- **Overflow.** With `FIFO_AW`=1 and `ev_ready`=0, a 6-key press → first 2 events retained, `overflow`=1; `ovf_clr` clears it.
- **conerr release.** With {04} held, a pulse on `conerr` → one 0x004 event, `report`=0, `new_packet` unchanged; a second frame arriving during busy is committed after IDLE.
